// File: rtl/accelerator_memory_pkg.sv
// Shared definitions for the memory matrix receiver.
//   - default constants for element width, control width and matrix bounds
//   - receiver FSM state type
//   - clamp_size(): limits a requested dimension to the buffer bound
package accelerator_memory_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE    = 64;
    localparam int unsigned DEFAULT_CONTROL_SIZE = 64;
    localparam int unsigned DEFAULT_R            = 64;
    localparam int unsigned DEFAULT_W            = 64;

    typedef enum logic [0:0] {
        StIdle,
        StWaitElement
    } rx_state_e;

    function automatic logic [63:0] clamp_size(input logic [63:0] size, input logic [63:0] limit);
        return (size > limit) ? limit : size;
    endfunction

endpackage

// File: rtl/accelerator_memory_matrix_receiver_if.sv
// Matrix-streaming handshake bundle between a sender and the receiver.
//   master : sender side (drives START, sizes, element strobes/data, readback indices)
//   slave  : receiver side (drives READY, request strobes, readback data)
interface accelerator_memory_matrix_receiver_if
    import accelerator_memory_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int unsigned CONTROL_SIZE = DEFAULT_CONTROL_SIZE
);
    logic                    start;
    logic                    ready;
    logic [CONTROL_SIZE-1:0] size_i;
    logic [CONTROL_SIZE-1:0] size_k;
    logic                    in_i_en;
    logic                    in_k_en;
    logic [DATA_SIZE-1:0]    data_in;
    logic                    out_i_en;
    logic                    out_k_en;
    logic [CONTROL_SIZE-1:0] rd_i;
    logic [CONTROL_SIZE-1:0] rd_k;
    logic [DATA_SIZE-1:0]    rd_data;

    modport master (
        output start, size_i, size_k, in_i_en, in_k_en, data_in, rd_i, rd_k,
        input  ready, out_i_en, out_k_en, rd_data
    );

    modport slave (
        input  start, size_i, size_k, in_i_en, in_k_en, data_in, rd_i, rd_k,
        output ready, out_i_en, out_k_en, rd_data
    );
endinterface

// File: rtl/accelerator_memory_matrix_buffer.sv
// R x W matrix store with one write port and one registered read port.
//   i_clk, i_rst             : clock, synchronous active-high reset (read register only)
//   i_wr_en/row/col/data     : element write
//   i_rd_row/col, o_rd_data  : one-cycle-latency readback, 0 when out of range
module accelerator_memory_matrix_buffer
    import accelerator_memory_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int unsigned CONTROL_SIZE = DEFAULT_CONTROL_SIZE,
    parameter int unsigned R            = DEFAULT_R,
    parameter int unsigned W            = DEFAULT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [CONTROL_SIZE-1:0] i_wr_row,
    input  logic [CONTROL_SIZE-1:0] i_wr_col,
    input  logic [DATA_SIZE-1:0]    i_wr_data,
    input  logic [CONTROL_SIZE-1:0] i_rd_row,
    input  logic [CONTROL_SIZE-1:0] i_rd_col,
    output logic [DATA_SIZE-1:0]    o_rd_data
);
    localparam int unsigned ROW_AW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned COL_AW = (W > 1) ? $clog2(W) : 1;

    logic [DATA_SIZE-1:0] r_mem [R][W];
    logic [DATA_SIZE-1:0] r_rd_data;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;

    assign w_wr_in_range = (i_wr_row < CONTROL_SIZE'(R)) && (i_wr_col < CONTROL_SIZE'(W));
    assign w_rd_in_range = (i_rd_row < CONTROL_SIZE'(R)) && (i_rd_col < CONTROL_SIZE'(W));

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_row[ROW_AW-1:0]][i_wr_col[COL_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[i_rd_row[ROW_AW-1:0]][i_rd_col[COL_AW-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/accelerator_memory_matrix_receiver.sv
// Responder end of the matrix-streaming handshake: receives an I x K matrix element by
// element, acknowledges each element with request strobes, stores it in a local buffer and
// pulses READY after the last element.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : handshake bundle (slave modport)
//   o_error      : sticky protocol error, only when ACCELERATOR_MEMORY_RECEIVER_CHECK_EN is defined
module accelerator_memory_matrix_receiver
    import accelerator_memory_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int unsigned CONTROL_SIZE = DEFAULT_CONTROL_SIZE,
    parameter int unsigned R            = DEFAULT_R,
    parameter int unsigned W            = DEFAULT_W
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
    output logic o_error,
`endif
    accelerator_memory_matrix_receiver_if.slave io_bus
);
    localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = CONTROL_SIZE'(1);

    rx_state_e               r_state;
    logic [CONTROL_SIZE-1:0] r_size_i;
    logic [CONTROL_SIZE-1:0] r_size_k;
    logic [CONTROL_SIZE-1:0] r_i;
    logic [CONTROL_SIZE-1:0] r_k;
    logic                    r_ready;
    logic                    r_out_i_en;
    logic                    r_out_k_en;

    logic [CONTROL_SIZE-1:0] w_clamp_i;
    logic [CONTROL_SIZE-1:0] w_clamp_k;
    logic                    w_accept;
    logic                    w_last_k;
    logic                    w_last_i;

    assign w_clamp_i = CONTROL_SIZE'(clamp_size(64'(io_bus.size_i), 64'(R)));
    assign w_clamp_k = CONTROL_SIZE'(clamp_size(64'(io_bus.size_k), 64'(W)));
    assign w_accept  = (r_state == StWaitElement) && io_bus.in_k_en;
    assign w_last_k  = (r_k == r_size_k - CTRL_ONE);
    assign w_last_i  = (r_i == r_size_i - CTRL_ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_size_i   <= '0;
            r_size_k   <= '0;
            r_i        <= '0;
            r_k        <= '0;
            r_ready    <= 1'b0;
            r_out_i_en <= 1'b0;
            r_out_k_en <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_out_i_en <= 1'b0;
            r_out_k_en <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_size_i <= w_clamp_i;
                        r_size_k <= w_clamp_k;
                        r_i      <= '0;
                        r_k      <= '0;
                        // An empty matrix completes at once without any request.
                        if (w_clamp_i == '0 || w_clamp_k == '0) begin
                            r_ready <= 1'b1;
                        end else begin
                            r_out_i_en <= 1'b1;
                            r_out_k_en <= 1'b1;
                            r_state    <= StWaitElement;
                        end
                    end
                end
                StWaitElement: begin
                    if (io_bus.in_k_en) begin
                        if (!w_last_k) begin
                            r_k        <= r_k + CTRL_ONE;
                            r_out_k_en <= 1'b1;
                        end else if (!w_last_i) begin
                            r_k        <= '0;
                            r_i        <= r_i + CTRL_ONE;
                            r_out_i_en <= 1'b1;
                            r_out_k_en <= 1'b1;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.ready    = r_ready;
    assign io_bus.out_i_en = r_out_i_en;
    assign io_bus.out_k_en = r_out_k_en;

    accelerator_memory_matrix_buffer #(
        .DATA_SIZE   (DATA_SIZE),
        .CONTROL_SIZE(CONTROL_SIZE),
        .R           (R),
        .W           (W)
    ) u_buffer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (w_accept),
        .i_wr_row (r_i),
        .i_wr_col (r_k),
        .i_wr_data(io_bus.data_in),
        .i_rd_row (io_bus.rd_i),
        .i_rd_col (io_bus.rd_k),
        .o_rd_data(io_bus.rd_data)
    );

`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
    logic r_error;
    logic w_start_acc;
    logic w_proto_err;

    assign w_start_acc = (r_state == StIdle) && io_bus.start;
    // Row marker missing on a row's first element, row marker mid-row, or stray element.
    assign w_proto_err = (w_accept && (r_k == '0) && !io_bus.in_i_en)
                      || ((r_state == StWaitElement) && io_bus.in_i_en && (r_k != '0))
                      || ((r_state == StIdle) && io_bus.in_k_en);

    // A violation in the START cycle itself still sets the flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (r_error && !w_start_acc) || w_proto_err;
        end
    end

    assign o_error = r_error;
`else
    logic w_unused_in_i_en;
    assign w_unused_in_i_en = io_bus.in_i_en;
`endif
endmodule

// File: tb/tb_accelerator_memory_matrix_receiver.sv
// Directed self-checking bench for accelerator_memory_matrix_receiver.
module tb_accelerator_memory_matrix_receiver;
    import accelerator_memory_pkg::*;

    localparam int unsigned DS = 64;
    localparam int unsigned CS = 64;

    logic clk = 1'b0;
    logic rst;
`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
    logic error;
`endif

    int checks = 0;
    int errors = 0;
    int mon_i = 0;
    int mon_k = 0;
    int mon_ready = 0;

    always #5 clk = ~clk;

    accelerator_memory_matrix_receiver_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

    accelerator_memory_matrix_receiver #(
        .DATA_SIZE   (DS),
        .CONTROL_SIZE(CS),
        .R           (64),
        .W           (64)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
        .o_error(error),
`endif
        .io_bus(bus)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_i_en === 1'b1) mon_i++;
        if (bus.out_k_en === 1'b1) mon_k++;
        if (bus.ready === 1'b1) mon_ready++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.size_i  = '0;
        bus.size_k  = '0;
        bus.in_i_en = 1'b0;
        bus.in_k_en = 1'b0;
        bus.data_in = '0;
        bus.rd_i    = '0;
        bus.rd_k    = '0;
    endtask

    task automatic do_start(input logic [63:0] si, input logic [63:0] sk);
        bus.size_i = si;
        bus.size_k = sk;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Sender: answers each request one cycle later with element base + row*nk + col.
    task automatic send_elems(input int nk, input int n_send, input logic [63:0] base,
                              input bit omit_row1_i, input int inject_at,
                              output int accepts, output bit timed_out);
        int row;
        int col;
        int waits;
        accepts   = 0;
        timed_out = 1'b0;
        for (int e = 0; e < n_send; e++) begin
            row   = e / nk;
            col   = e % nk;
            waits = 0;
            while (bus.out_k_en !== 1'b1 && waits < 10) begin
                tick();
                waits++;
            end
            if (bus.out_k_en !== 1'b1) begin
                timed_out = 1'b1;
                break;
            end
            if (e == inject_at) begin
                bus.size_i = 7;
                bus.size_k = 7;
                bus.start  = 1'b1;
            end
            tick();
            bus.start   = 1'b0;
            bus.in_k_en = 1'b1;
            bus.in_i_en = (col == 0) && !(omit_row1_i && row == 1);
            bus.data_in = base + 64'(row * nk + col);
            tick();
            bus.in_k_en = 1'b0;
            bus.in_i_en = 1'b0;
            accepts++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.ready !== 1'b0 || bus.out_i_en !== 1'b0 || bus.out_k_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: ready=%b out_i=%b out_k=%b, required 0 0 0",
                     bus.ready, bus.out_i_en, bus.out_k_en);
        end
        checks++;
        if (bus.rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h, required 0", bus.rd_data);
        end
`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b, required 0", error);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s_i;
        int s_k;
        int s_r;
        int acc;
        bit to;
        s_i = mon_i;
        s_k = mon_k;
        s_r = mon_ready;
        do_start(2, 3);
        checks++;
        if (bus.out_i_en !== 1'b1 || bus.out_k_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_req: out_i=%b out_k=%b, required 1 1",
                     bus.out_i_en, bus.out_k_en);
        end
        send_elems(3, 6, 64'h10, 1'b0, -1, acc, to);
        checks++;
        if (to !== 1'b0 || acc != 6) begin
            errors++;
            $display("FAIL basic_accepts: timeout=%b accepts=%0d, required 0 6", to, acc);
        end
        checks++;
        if (bus.ready !== 1'b1 || bus.out_i_en !== 1'b0 || bus.out_k_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready: ready=%b out_i=%b out_k=%b, required 1 0 0",
                     bus.ready, bus.out_i_en, bus.out_k_en);
        end
        checks++;
        if (mon_i - s_i != 2 || mon_k - s_k != 6) begin
            errors++;
            $display("FAIL basic_req_counts: out_i=%0d out_k=%0d, required 2 6",
                     mon_i - s_i, mon_k - s_k);
        end
        tick();
        checks++;
        if (bus.ready !== 1'b0 || mon_ready - s_r != 1) begin
            errors++;
            $display("FAIL basic_ready_pulse: ready=%b pulses=%0d, required 0 1",
                     bus.ready, mon_ready - s_r);
        end
        bus.rd_i = 1;
        bus.rd_k = 2;
        tick();
        checks++;
        if (bus.rd_data !== 64'h15) begin
            errors++;
            $display("FAIL basic_rd_1_2: got %h, required 15", bus.rd_data);
        end
        bus.rd_i = 0;
        bus.rd_k = 1;
        tick();
        checks++;
        if (bus.rd_data !== 64'h11) begin
            errors++;
            $display("FAIL basic_rd_0_1: got %h, required 11", bus.rd_data);
        end
        bus.rd_i = 64;
        bus.rd_k = 0;
        tick();
        checks++;
        if (bus.rd_data !== 64'h0) begin
            errors++;
            $display("FAIL basic_rd_out_of_range: got %h, required 0", bus.rd_data);
        end
    endtask

    task automatic test_zero_size();
        int s_k;
        s_k = mon_k;
        do_start(0, 4);
        checks++;
        if (bus.ready !== 1'b1 || bus.out_i_en !== 1'b0 || bus.out_k_en !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready: ready=%b out_i=%b out_k=%b, required 1 0 0",
                     bus.ready, bus.out_i_en, bus.out_k_en);
        end
        tick();
        tick();
        checks++;
        if (bus.ready !== 1'b0 || mon_k - s_k != 0) begin
            errors++;
            $display("FAIL zero_quiet: ready=%b req_k=%0d, required 0 0", bus.ready, mon_k - s_k);
        end
    endtask

    task automatic test_clamp();
        int s_i;
        int s_k;
        int acc;
        bit to;
        s_i = mon_i;
        s_k = mon_k;
        do_start(100, 1);
        send_elems(1, 64, 64'h100, 1'b0, -1, acc, to);
        checks++;
        if (to !== 1'b0 || acc != 64 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done: timeout=%b accepts=%0d ready=%b, required 0 64 1",
                     to, acc, bus.ready);
        end
        tick();
        tick();
        checks++;
        if (mon_i - s_i != 64 || mon_k - s_k != 64) begin
            errors++;
            $display("FAIL clamp_rows: out_i=%0d out_k=%0d, required 64 64",
                     mon_i - s_i, mon_k - s_k);
        end
        bus.rd_i = 63;
        bus.rd_k = 0;
        tick();
        checks++;
        if (bus.rd_data !== 64'h13F) begin
            errors++;
            $display("FAIL clamp_rd_63_0: got %h, required 13f", bus.rd_data);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit to;
        do_start(2, 3);
        send_elems(3, 3, 64'h50, 1'b0, -1, acc, to);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.ready !== 1'b0 || bus.out_i_en !== 1'b0 || bus.out_k_en !== 1'b0 ||
            bus.rd_data !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: ready=%b out_i=%b out_k=%b rd=%h, required 0 0 0 0",
                     bus.ready, bus.out_i_en, bus.out_k_en, bus.rd_data);
        end
        rst = 1'b0;
        do_start(1, 1);
        checks++;
        if (bus.out_i_en !== 1'b1 || bus.out_k_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: out_i=%b out_k=%b, required 1 1",
                     bus.out_i_en, bus.out_k_en);
        end
        send_elems(1, 1, 64'hAB, 1'b0, -1, acc, to);
        checks++;
        if (to !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: timeout=%b ready=%b, required 0 1", to, bus.ready);
        end
        bus.rd_i = 0;
        bus.rd_k = 0;
        tick();
        checks++;
        if (bus.rd_data !== 64'hAB) begin
            errors++;
            $display("FAIL rstmid_rd_0_0: got %h, required ab", bus.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int s_i;
        int s_k;
        int acc;
        bit to;
        s_i = mon_i;
        s_k = mon_k;
        do_start(2, 3);
        send_elems(3, 6, 64'h20, 1'b0, 2, acc, to);
        checks++;
        if (to !== 1'b0 || acc != 6 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignored_start: timeout=%b accepts=%0d ready=%b, required 0 6 1",
                     to, acc, bus.ready);
        end
        checks++;
        if (mon_i - s_i != 2 || mon_k - s_k != 6) begin
            errors++;
            $display("FAIL b2b_req_counts: out_i=%0d out_k=%0d, required 2 6",
                     mon_i - s_i, mon_k - s_k);
        end
        // START in the READY cycle.
        do_start(1, 2);
        checks++;
        if (bus.out_i_en !== 1'b1 || bus.out_k_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_on_ready: out_i=%b out_k=%b, required 1 1",
                     bus.out_i_en, bus.out_k_en);
        end
        send_elems(2, 2, 64'h30, 1'b0, -1, acc, to);
        checks++;
        if (to !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ready: timeout=%b ready=%b, required 0 1", to, bus.ready);
        end
        bus.rd_i = 0;
        bus.rd_k = 1;
        tick();
        checks++;
        if (bus.rd_data !== 64'h31) begin
            errors++;
            $display("FAIL b2b_rd_0_1: got %h, required 31", bus.rd_data);
        end
        bus.rd_i = 1;
        bus.rd_k = 2;
        tick();
        checks++;
        if (bus.rd_data !== 64'h25) begin
            errors++;
            $display("FAIL b2b_rd_1_2: got %h, required 25", bus.rd_data);
        end
    endtask

    task automatic test_protocol();
        int acc;
        bit to;
        do_start(2, 3);
        send_elems(3, 6, 64'h40, 1'b1, -1, acc, to);
        checks++;
        if (to !== 1'b0 || acc != 6 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL proto_complete: timeout=%b accepts=%0d ready=%b, required 0 6 1",
                     to, acc, bus.ready);
        end
`ifdef ACCELERATOR_MEMORY_RECEIVER_CHECK_EN
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL proto_error_set: got %b, required 1", error);
        end
        tick();
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL proto_error_sticky: got %b, required 1", error);
        end
        do_start(1, 1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL proto_error_clear: got %b, required 0", error);
        end
        send_elems(1, 1, 64'h77, 1'b0, -1, acc, to);
        tick();
`endif
        bus.rd_i = 1;
        bus.rd_k = 0;
        tick();
        checks++;
        if (bus.rd_data !== 64'h43) begin
            errors++;
            $display("FAIL proto_rd_1_0: got %h, required 43", bus.rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
